// File: rtl/score_display_scanner_pkg.sv
// Shared 7-segment definitions: segment bit positions, active-high glyphs 0-F,
// and the slot-type enum used by the anode scanner.
package display_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] M_A = 8'(1) << SEG_A;
  localparam logic [7:0] M_B = 8'(1) << SEG_B;
  localparam logic [7:0] M_C = 8'(1) << SEG_C;
  localparam logic [7:0] M_D = 8'(1) << SEG_D;
  localparam logic [7:0] M_E = 8'(1) << SEG_E;
  localparam logic [7:0] M_F = 8'(1) << SEG_F;
  localparam logic [7:0] M_G = 8'(1) << SEG_G;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high glyphs; polarity is applied only at the output register.
  localparam logic [7:0] SEG_GLYPH_0 = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [7:0] SEG_GLYPH_1 = M_B | M_C;
  localparam logic [7:0] SEG_GLYPH_2 = M_A | M_B | M_D | M_E | M_G;
  localparam logic [7:0] SEG_GLYPH_3 = M_A | M_B | M_C | M_D | M_G;
  localparam logic [7:0] SEG_GLYPH_4 = M_B | M_C | M_F | M_G;
  localparam logic [7:0] SEG_GLYPH_5 = M_A | M_C | M_D | M_F | M_G;
  localparam logic [7:0] SEG_GLYPH_6 = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [7:0] SEG_GLYPH_7 = M_A | M_B | M_C;
  localparam logic [7:0] SEG_GLYPH_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [7:0] SEG_GLYPH_9 = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [7:0] SEG_GLYPH_A = M_A | M_B | M_C | M_E | M_F | M_G;
  localparam logic [7:0] SEG_GLYPH_B = M_C | M_D | M_E | M_F | M_G;
  localparam logic [7:0] SEG_GLYPH_C = M_A | M_D | M_E | M_F;
  localparam logic [7:0] SEG_GLYPH_D = M_B | M_C | M_D | M_E | M_G;
  localparam logic [7:0] SEG_GLYPH_E = M_A | M_D | M_E | M_F | M_G;
  localparam logic [7:0] SEG_GLYPH_F = M_A | M_E | M_F | M_G;

  typedef enum logic {
    SLOT_DATA  = 1'b0,
    SLOT_GHOST = 1'b1
  } slot_e;

  function automatic logic [7:0] seg_glyph(input logic [3:0] nibble);
    logic [7:0] g;
    case (nibble)
      4'h0:    g = SEG_GLYPH_0;
      4'h1:    g = SEG_GLYPH_1;
      4'h2:    g = SEG_GLYPH_2;
      4'h3:    g = SEG_GLYPH_3;
      4'h4:    g = SEG_GLYPH_4;
      4'h5:    g = SEG_GLYPH_5;
      4'h6:    g = SEG_GLYPH_6;
      4'h7:    g = SEG_GLYPH_7;
      4'h8:    g = SEG_GLYPH_8;
      4'h9:    g = SEG_GLYPH_9;
      4'hA:    g = SEG_GLYPH_A;
      4'hB:    g = SEG_GLYPH_B;
      4'hC:    g = SEG_GLYPH_C;
      4'hD:    g = SEG_GLYPH_D;
      4'hE:    g = SEG_GLYPH_E;
      default: g = SEG_GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/score_display_scanner_if.sv
// Bundle between the score counter chain / board pins and the display scanner.
interface score_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] digits;
  logic                    ovf_in;
  logic                    latch_en;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   AN;
  logic [7:0]              SEGMENT;
  logic [IDX_W-1:0]        digit_idx;

  modport master (
    output digits, ovf_in, latch_en, blank_lz,
    input  AN, SEGMENT, digit_idx
  );

  modport slave (
    input  digits, ovf_in, latch_en, blank_lz,
    output AN, SEGMENT, digit_idx
  );
endinterface

// File: rtl/score_display_scanner_seg7_decode.sv
// Combinational nibble + blank + dp to active-high {dp,g..a}; shared by any display.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      o_seg         = seg_glyph(i_nibble);
      o_seg[SEG_DP] = i_dp;
    end
  end

endmodule

// File: rtl/score_display_scanner.sv
// Snapshots score digits, blanks leading zeros and scans them onto a common
// 7-segment display, inserting a one-cycle dark slot at every digit change.
module score_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                     CP,
  input logic                     clear,
  score_display_scanner_if.slave  bus
);
  import display_pkg::*;

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = $clog2(SCAN_DIV);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]         SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [PRESC_W-1:0]      r_presc;
  logic [IDX_W-1:0]        r_digit_idx;
  logic [4*NUM_DIGITS-1:0] r_snapshot;
  logic                    r_ovf_flag;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_seg;

  logic                    w_tick;
  slot_e                   w_slot;
  logic [3:0]              w_snap_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_blank_vec;
  logic [3:0]              w_nibble;
  logic                    w_blank;
  logic                    w_dp;
  logic [7:0]              w_seg_hi;
  logic [NUM_DIGITS-1:0]   w_an_sel;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_slot = w_tick ? SLOT_GHOST : SLOT_DATA;

  // Prescaler and digit index
  always_ff @(posedge CP or posedge clear) begin
    if (clear) begin
      r_presc     <= '0;
      r_digit_idx <= '0;
    end else if (w_tick) begin
      r_presc     <= '0;
      r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + IDX_W'(1);
    end else begin
      r_presc     <= r_presc + PRESC_W'(1);
    end
  end

  // Snapshot and sticky overflow; both frozen while latch_en is low.
  always_ff @(posedge CP or posedge clear) begin
    if (clear) begin
      r_snapshot <= '0;
      r_ovf_flag <= 1'b0;
    end else if (bus.latch_en) begin
      r_snapshot <= bus.digits;
      if (bus.ovf_in) begin
        r_ovf_flag <= 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every more-significant digit are 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_snap_digit[gi] = r_snapshot[4*gi +: 4];
      assign w_upper_zero[gi] = ~|r_snapshot[4*NUM_DIGITS-1 : 4*gi];
      if (gi == 0) begin : g_lsd
        assign w_blank_vec[gi] = 1'b0;
      end else begin : g_upper
        assign w_blank_vec[gi] = bus.blank_lz & w_upper_zero[gi];
      end
    end
  endgenerate

  assign w_nibble = w_snap_digit[r_digit_idx];
  assign w_blank  = w_blank_vec[r_digit_idx];
  assign w_dp     = r_ovf_flag && (r_digit_idx == IDX_LAST);
  assign w_an_sel = NUM_DIGITS'(1) << r_digit_idx;

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .i_dp     (w_dp),
    .o_seg    (w_seg_hi)
  );

  // Output register; the tick cycle loads the dark ghost slot.
  always_ff @(posedge CP or posedge clear) begin
    if (clear) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
    end else begin
      case (w_slot)
        SLOT_GHOST: begin
          r_an  <= '1;
          r_seg <= SEG_OFF;
        end
        default: begin
          r_an  <= ~w_an_sel;
          r_seg <= SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
        end
      endcase
    end
  end

  assign bus.AN        = r_an;
  assign bus.SEGMENT   = r_seg;
  assign bus.digit_idx = r_digit_idx;

endmodule

// File: doc/score_display_scanner.md
Name: score_display_scanner

Overview:
Display-side consumer of the cascaded score counter chain (4-bit digit counters plus carry).
- Snapshots the digit nibbles and the final carry.
- Applies optional leading-zero blanking.
- Time-multiplexes the digits onto a common 7-segment display with anode scanning.
- Inserts a ghost-suppression blank slot whenever the scanned digit changes.
- Sits between the score counters and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; digit 0 is least significant.
- SCAN_DIV, 50000: CP cycles per digit slot, must be ≥2; benches override it to 4.
- SEG_ACTIVE_LOW, 1: 1 means SEGMENT bits are driven low-active; 0 means high-active.

Ports:
- CP, input, 1: system clock; all state changes on its rising edge.
- clear, input, 1: asynchronous active-high reset.
- digits, input, 4*NUM_DIGITS: digit nibbles; digit k occupies bits [4k+3:4k].
- ovf_in, input, 1: carry out of the most-significant counter; score overflow.
- latch_en, input, 1: 1 tracks the input every cycle; 0 freezes the snapshot (game-over hold).
- blank_lz, input, 1: enables leading-zero blanking.
- AN, output, NUM_DIGITS: digit enables, active-low, one-hot-low when a digit is shown.
- SEGMENT, output, 8: {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- digit_idx, output, clog2(NUM_DIGITS): index of the digit currently scanned, for debug.

Behaviour:
- Reset (clear=1, asynchronous, overrides everything), applied immediately and held:
  - prescaler=0, digit_idx=0, snapshot=0, ovf_flag=0.
  - AN=all 1s; SEGMENT=all off (8'hFF if SEG_ACTIVE_LOW, else 8'h00).
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick=1 in the cycle where prescaler==SCAN_DIV-1.
  - On tick, digit_idx advances; NUM_DIGITS-1 wraps to 0.
- Snapshot:
  - latch_en=1: snapshot<=digits every cycle.
  - latch_en=0: snapshot holds.
- ovf_flag:
  - Set when ovf_in=1 and latch_en=1 in the same cycle.
  - Sticky; cleared only by clear.
- Leading-zero blanking:
  - Digit k (k≥1) is blank when blank_lz=1 and snapshot digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - A value of 0000 therefore shows a single "0".
- Decode:
  - Nibbles 0-9 map to decimal glyphs.
  - Nibbles 10-15 map to hex glyphs A,b,C,d,E,F; this keeps counter faults visible.
  - dp is lit only on digit NUM_DIGITS-1, and only when ovf_flag=1.
  - A blank digit drives all segments off, dp included.
- Output stage (registered):
  - The cycle after tick: AN=all 1s (ghost slot, one cycle).
  - Every other cycle:
    - AN has bit digit_idx low, all other bits high.
    - SEGMENT = decode of snapshot[digit_idx] under the current blank and dp rules.
  - If the scanned digit is blank, AN still selects it and SEGMENT is all off.
- Latency:
  - digits change → SEGMENT change: 2 cycles (snapshot register, then output register), with latch_en=1 and the digit being scanned.
  - Ghost slot takes priority over data in its cycle.
- Simultaneous events:
  - tick and a snapshot load in the same cycle: both take effect; the next visible digit uses the new snapshot.
  - ovf_in while latch_en=0: ignored.
- Reset mid-scan: outputs go dark immediately; the scan restarts at digit 0 with a full SCAN_DIV slot after clear deasserts.
- Width rules:
  - Prescaler width is clog2(SCAN_DIV).
  - No arithmetic is performed on digit values.

Decomposition:
- Shared package (display_pkg):
  - SEG glyph constants 0-F in active-high form.
  - SEG_BLANK constant.
  - Segment bit-position constants.
- Polarity inversion is applied only at the output register.
- One sub-module: seg7_decode, combinational nibble+blank+dp → 8 active-high segments.
  - Reused by any future display (high-score, timer).

Test Plan:
1. Reset and scan order (SCAN_DIV=4, NUM_DIGITS=4):
   - Stimulus: hold clear 3 cycles, release.
   - Required: AN=4'b1111 and SEGMENT=8'hFF during clear; after release, AN goes 1110, then ghost 1111, then 1101, then 1011, then 0111, then wraps; each digit shows 3 cycles with 1 ghost cycle.
2. Decimal decode (active-low):
   - Stimulus: digits=16'h0129, blank_lz=0, latch_en=1.
   - Required: slots show 8'hC0 ("0"), 8'hF9 ("1"), 8'hA4 ("2"), 8'h90 ("9") for digits 3..0.
3. Leading-zero blanking:
   - Stimulus: digits=16'h0007, blank_lz=1.
   - Required: digits 3,2,1 show SEGMENT=8'hFF with AN still selecting them; digit 0 shows 8'hF8.
   - Stimulus: digits=16'h0000.
   - Required: only digit 0 shows 8'hC0.
4. Freeze:
   - Stimulus: set digits=16'h0042 with latch_en=1; drop latch_en to 0; change digits to 16'h0099.
   - Required: display keeps showing 0042 until latch_en returns to 1.
   - Required: 2 cycles after re-enable (while the digit is being scanned), the new value appears.
5. Overflow:
   - Stimulus: pulse ovf_in 1 cycle with latch_en=1; then drive ovf_in=0.
   - Required: dp (bit 7) is low only in digit-3 slots, persisting after ovf_in=0.
   - Stimulus: pulse ovf_in with latch_en=0.
   - Required: no effect.
6. Hex fault glyph and async reset mid-slot:
   - Stimulus: digit 0 = 4'hA.
   - Required: digit 0 shows 8'h88.
   - Stimulus: assert clear between clock edges.
   - Required: AN=1111 before the next CP edge.
